// File: rtl/l2_cache_control_nway_if.sv
// Bundle of the CPU-side, memory-side and datapath signals of the N-way L2 controller.
// The slave modport is the controller's view; master is the environment driving it.
interface l2_cache_control_nway_if #(
  parameter int WAYS  = 4,
  parameter int CNT_W = 32
);
  localparam int WIDX = $clog2(WAYS);

  logic             mem_read;
  logic             mem_write;
  logic [WAYS-1:0]  hit_vec;
  logic [WAYS-1:0]  valid_vec;
  logic [WAYS-1:0]  dirty_vec;
  logic [WIDX-1:0]  lru_way;
  logic             pmem_resp;
  logic             cnt_clr;

  logic             mem_resp;
  logic             pmem_read;
  logic             pmem_write;
  logic             read_arrays;
  logic [WIDX-1:0]  way_sel;
  logic             addr_sel;
  logic             load_data;
  logic             load_tag;
  logic             set_valid;
  logic             set_dirty;
  logic             clear_dirty;
  logic             load_lru;
  logic             multi_hit;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;
  logic [CNT_W-1:0] wb_count;

  modport slave (
    input  mem_read, mem_write, hit_vec, valid_vec, dirty_vec, lru_way, pmem_resp, cnt_clr,
    output mem_resp, pmem_read, pmem_write, read_arrays, way_sel, addr_sel, load_data,
           load_tag, set_valid, set_dirty, clear_dirty, load_lru, multi_hit,
           hit_count, miss_count, wb_count
  );

  modport master (
    output mem_read, mem_write, hit_vec, valid_vec, dirty_vec, lru_way, pmem_resp, cnt_clr,
    input  mem_resp, pmem_read, pmem_write, read_arrays, way_sel, addr_sel, load_data,
           load_tag, set_valid, set_dirty, clear_dirty, load_lru, multi_hit,
           hit_count, miss_count, wb_count
  );
endinterface

// File: rtl/l2_cache_control_nway.sv
// N-way L2 cache controller FSM: serves one request at a time, picks a victim
// (invalid way first, else LRU), writes back dirty victims, fills, then re-checks
// so the CPU response always comes from a hit. Keeps saturating perf counters.
module l2_cache_control_nway #(
  parameter int WAYS  = 4,
  parameter int CNT_W = 32
) (
  input logic                   clk,
  input logic                   rst,
  l2_cache_control_nway_if.slave bus
);
  localparam int WIDX = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, FILL, SETTLE} state_t;

  state_t           state, state_next;
  logic [WIDX-1:0]  victim_q;
  logic             retry_q;
  logic             multi_q;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

  logic [WIDX-1:0]  hit_way, inv_way, victim_c;
  logic             hit_any, inv_found, multi_c, victim_dirty;
  logic             victim_load, retry_set, retry_clr, multi_set;
  logic             hit_inc, miss_inc, wb_inc;

  // Saturating counter step; a clear takes priority over any increment.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic inc,
                                            input logic clr);
    if (clr) return '0;
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  // Lowest-index hit way, lowest-index invalid way and the resulting victim choice.
  always_comb begin
    hit_way   = '0;
    inv_way   = '0;
    inv_found = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit_vec[i]) hit_way = WIDX'(i);
      if (!bus.valid_vec[i]) begin
        inv_way   = WIDX'(i);
        inv_found = 1'b1;
      end
    end
    hit_any      = |bus.hit_vec;
    multi_c      = (bus.hit_vec & (bus.hit_vec - WAYS'(1))) != '0;
    victim_c     = inv_found ? inv_way : bus.lru_way;
    victim_dirty = bus.valid_vec[victim_c] & bus.dirty_vec[victim_c];
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next      = state;
    bus.mem_resp    = 1'b0;
    bus.pmem_read   = 1'b0;
    bus.pmem_write  = 1'b0;
    bus.read_arrays = 1'b0;
    bus.way_sel     = '0;
    bus.addr_sel    = 1'b0;
    bus.load_data   = 1'b0;
    bus.load_tag    = 1'b0;
    bus.set_valid   = 1'b0;
    bus.set_dirty   = 1'b0;
    bus.clear_dirty = 1'b0;
    bus.load_lru    = 1'b0;
    victim_load     = 1'b0;
    retry_set       = 1'b0;
    retry_clr       = 1'b0;
    multi_set       = 1'b0;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    wb_inc          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          bus.read_arrays = 1'b1;
          state_next      = CHECK;
        end
      end
      CHECK: begin
        if (hit_any) begin
          bus.way_sel  = hit_way;
          bus.mem_resp = 1'b1;
          bus.load_lru = 1'b1;
          if (bus.mem_write) begin
            bus.load_data = 1'b1;
            bus.set_dirty = 1'b1;
          end
          retry_clr  = 1'b1;
          hit_inc    = !retry_q;
          multi_set  = multi_c;
          state_next = IDLE;
        end else begin
          victim_load = 1'b1;
          miss_inc    = !retry_q;
          state_next  = victim_dirty ? WRITEBACK : FILL;
        end
      end
      WRITEBACK: begin
        bus.pmem_write = 1'b1;
        bus.addr_sel   = 1'b1;
        bus.way_sel    = victim_q;
        if (bus.pmem_resp) begin
          bus.clear_dirty = 1'b1;
          wb_inc          = 1'b1;
          state_next      = FILL;
        end
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        bus.way_sel   = victim_q;
        if (bus.pmem_resp) begin
          bus.load_data   = 1'b1;
          bus.load_tag    = 1'b1;
          bus.set_valid   = 1'b1;
          bus.clear_dirty = 1'b1;
          retry_set       = 1'b1;
          state_next      = SETTLE;
        end
      end
      SETTLE: begin
        bus.read_arrays = 1'b1;
        state_next      = CHECK;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, victim, retry flag, sticky multi-hit error and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      victim_q   <= '0;
      retry_q    <= 1'b0;
      multi_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      state <= state_next;
      if (victim_load) victim_q <= victim_c;
      if (retry_clr) retry_q <= 1'b0;
      else if (retry_set) retry_q <= 1'b1;
      if (multi_set) multi_q <= 1'b1;
      hit_cnt_q  <= bump(hit_cnt_q, hit_inc, bus.cnt_clr);
      miss_cnt_q <= bump(miss_cnt_q, miss_inc, bus.cnt_clr);
      wb_cnt_q   <= bump(wb_cnt_q, wb_inc, bus.cnt_clr);
    end
  end

  assign bus.multi_hit  = multi_q;
  assign bus.hit_count  = hit_cnt_q;
  assign bus.miss_count = miss_cnt_q;
  assign bus.wb_count   = wb_cnt_q;
endmodule

// File: doc/l2_cache_control_nway.md
Name: l2_cache_control_nway

Overview:
Parametrised N-way successor to the 2-way L2 cache controller FSM. It drives the L2 datapath for one request at a time, between the L1/arbiter side (mem_*) and physical memory (pmem_*). It adds:
- generic way count
- victim selection that prefers an invalid way and otherwise uses the LRU way supplied by the datapath
- a registered victim way
- a re-check after fill, so the CPU response always comes from a hit
- saturating hit/miss/writeback performance counters

Parameters:
WAYS, 4, number of ways (power of 2, ≥2)
WIDX, $clog2(WAYS), way index width (derived, not overridden)
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU-side read request, held until mem_resp
mem_write  in  1  CPU-side write request, held until mem_resp
hit_vec  in  WAYS  per-way tag-match AND valid for the current address
valid_vec  in  WAYS  per-way valid bits of the indexed set
dirty_vec  in  WAYS  per-way dirty bits of the indexed set
lru_way  in  WIDX  LRU way of the indexed set, from the datapath PLRU array
pmem_resp  in  1  physical memory completion, single-cycle pulse
cnt_clr  in  1  clears all counters
mem_resp  out  1  CPU-side completion pulse
pmem_read  out  1  memory read request, level
pmem_write  out  1  memory write request, level
read_arrays  out  1  array read enable (results valid the next cycle)
way_sel  out  WIDX  way targeted by load_* / set_* / clear_dirty
addr_sel  out  1  0 = CPU address, 1 = victim tag/index address (writeback)
load_data  out  1  write the line into way_sel
load_tag  out  1  write the tag into way_sel
set_valid  out  1  set valid[way_sel]
set_dirty  out  1  set dirty[way_sel]
clear_dirty  out  1  clear dirty[way_sel]
load_lru  out  1  update PLRU to mark way_sel most-recently used
multi_hit  out  1  sticky error: more than one hit_vec bit set in CHECK
hit_count  out  CNT_W  requests that hit on first check
miss_count  out  CNT_W  requests that missed on first check
wb_count  out  CNT_W  completed writebacks

Behaviour:
- States: IDLE, CHECK, WRITEBACK, FILL, SETTLE. State and all registers update on posedge clk.
- Outputs are combinational from state and inputs; all are 0 unless stated. way_sel=0 and addr_sel=0 by default.
- Reset: state=IDLE, victim reg=0, retry flag=0, multi_hit=0, all counters=0. The rst cycle overrides any in-flight state, including a mid-WRITEBACK or mid-FILL reset; no pmem request is asserted in the cycle after rst.
- IDLE: when (mem_read|mem_write), assert read_arrays and go to CHECK. mem_read and mem_write both high are treated as a write.
- CHECK, hit (|hit_vec):
  - hit way = lowest set index; way_sel = hit way.
  - Assert mem_resp and load_lru.
  - Write: also load_data and set_dirty.
  - Go to IDLE; clear retry flag.
  - Increment hit_count only if retry flag = 0.
  - If popcount(hit_vec) > 1, set multi_hit. It clears only on rst.
- CHECK, miss:
  - victim = lowest-index way with valid_vec=0; if all ways are valid, victim = lru_way. Latch victim into the victim reg.
  - Increment miss_count only if retry flag = 0.
  - If valid_vec[victim] & dirty_vec[victim], go to WRITEBACK; else go to FILL.
  - No mem_resp on a miss.
- WRITEBACK:
  - Assert pmem_write, addr_sel=1, way_sel=victim reg; hold until pmem_resp.
  - On pmem_resp: pulse clear_dirty, increment wb_count, go to FILL.
- FILL:
  - Assert pmem_read, addr_sel=0, way_sel=victim reg; hold until pmem_resp.
  - On pmem_resp: pulse load_data, load_tag, set_valid and clear_dirty (same cycle); set retry flag; go to SETTLE.
- SETTLE: assert read_arrays; go to CHECK. The re-check must hit and then serves the request. A write performs its merge in CHECK via load_data+set_dirty.
- Latency:
  - Hit: mem_resp 2 cycles after the request is sampled in IDLE.
  - Clean miss: 2 + (pmem latency) + 2.
  - Dirty miss: adds one full writeback.
- Counters:
  - Saturate at all-ones and do not wrap.
  - cnt_clr zeroes them next cycle; cnt_clr wins over a simultaneous increment.
- pmem_read and pmem_write are never asserted together. A pmem_resp seen in IDLE, CHECK or SETTLE is ignored.

Test Plan:
- WAYS=4, read with hit_vec=4'b0100 in CHECK → mem_resp and load_lru in CHECK, way_sel=2; hit_count=1; back to IDLE next cycle.
- Write miss, valid_vec=4'b1011, dirty_vec=4'b1111 → victim=2 (invalid preferred over lru_way=0), no writeback. FILL: pmem_read held 5 cycles until pmem_resp. SETTLE→CHECK hit: load_data+set_dirty, way_sel=2. miss_count=1, hit_count=0.
- Read miss, valid_vec=4'b1111, dirty_vec=4'b1000, lru_way=3:
  - WRITEBACK: pmem_write, addr_sel=1, way_sel=3.
  - On resp: clear_dirty, wb_count=1.
  - Then FILL with pmem_read, then mem_resp after the re-check.
- hit_vec=4'b0110 → way_sel=1, multi_hit=1. multi_hit stays 1 through later requests until rst.
- rst asserted on the 3rd cycle of WRITEBACK → next cycle state=IDLE, pmem_write=0, counters=0, victim reg=0. A request issued afterwards completes normally.
- Counters with CNT_W=2: 5 hits → hit_count saturates at 3. cnt_clr coincident with a hit → hit_count=0.
